// File: rtl/sal_apb_csr.sv
// APB completer CSR block for the SAL DDR controller: control, status, timing and scratch registers.
// Optional feature: define SAL_APB_CSR_LOCK_EN for a sticky CTRL[31] lock over timing/refresh config.
module sal_apb_csr #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] VERSION     = 32'h0002_0000,
  parameter logic [31:0] TIMING0_RST = 32'h1C0E_0E0E,
  parameter logic [31:0] TIMING1_RST = 32'h0058_0C30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr,
  input  logic        init_done_i,
  input  logic        busy_i,
  output logic        init_start_o,
  output logic        auto_ref_en_o,
  output logic [7:0]  t_rcd_o,
  output logic [7:0]  t_rp_o,
  output logic [7:0]  t_ras_o,
  output logic [7:0]  t_rc_o,
  output logic [15:0] t_refi_o,
  output logic [7:0]  t_rfc_o
);

  localparam logic [3:0] LpWait     = 4'(WAIT_CYCLES);
  localparam logic [9:0] OffVersion = 10'h000;
  localparam logic [9:0] OffCtrl    = 10'h001;
  localparam logic [9:0] OffStatus  = 10'h002;
  localparam logic [9:0] OffTiming0 = 10'h003;
  localparam logic [9:0] OffTiming1 = 10'h004;
  localparam logic [9:0] OffScratch = 10'h005;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic        r_pready;
  logic [31:0] r_prdata;
  logic        r_pslverr;
  logic        r_init_start;
  logic        r_auto_ref_en;
  logic [31:0] r_timing0;
  logic [23:0] r_timing1;
  logic [31:0] r_scratch;

  logic [9:0]  w_off;
  logic [31:0] w_rdata;
  logic        w_err;
  logic        w_lock;
  logic        w_commit;
  logic        w_wr_en;
  logic        w_unused;

  // Only the word offset within the 4 KiB window is decoded.
  assign w_off    = paddr[11:2];
  assign w_unused = ^{paddr[31:12], paddr[1:0]};

  always_comb begin
    w_rdata = '0;
    w_err   = 1'b0;
    case (w_off)
      OffVersion: begin
        w_rdata = VERSION;
        w_err   = pwrite;
      end
      OffCtrl: begin
        w_rdata = {w_lock, 29'd0, r_auto_ref_en, 1'b0};
        // Under lock only an attempt to change the refresh enable is refused.
        w_err   = pwrite & w_lock & (pwdata[1] ^ r_auto_ref_en);
      end
      OffStatus: begin
        w_rdata = {30'd0, busy_i, init_done_i};
        w_err   = pwrite;
      end
      OffTiming0: begin
        w_rdata = r_timing0;
        w_err   = pwrite & w_lock;
      end
      OffTiming1: begin
        w_rdata = {8'd0, r_timing1};
        w_err   = pwrite & w_lock;
      end
      OffScratch: w_rdata = r_scratch;
      default:    w_err   = 1'b1;
    endcase
  end

  assign w_commit = (r_state == StWait) & psel & penable & (r_cnt == LpWait);
  assign w_wr_en  = w_commit & pwrite & ~w_err;

`ifdef SAL_APB_CSR_LOCK_EN
  logic r_lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock <= 1'b0;
    end else if (w_wr_en && (w_off == OffCtrl) && pwdata[31]) begin
      r_lock <= 1'b1;
    end
  end

  assign w_lock = r_lock;
`else
  assign w_lock = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_cnt         <= 4'd0;
      r_pready      <= 1'b0;
      r_prdata      <= '0;
      r_pslverr     <= 1'b0;
      r_init_start  <= 1'b0;
      r_auto_ref_en <= 1'b0;
      r_timing0     <= TIMING0_RST;
      r_timing1     <= TIMING1_RST[23:0];
      r_scratch     <= '0;
    end else begin
      r_init_start <= 1'b0;
      case (r_state)
        StIdle: begin
          if (psel && !penable) begin
            r_state <= StWait;
            r_cnt   <= 4'd0;
          end
        end
        StWait: begin
          if (!psel) begin
            r_state <= StIdle;
          end else if (penable) begin
            if (w_commit) begin
              r_state   <= StResp;
              r_pready  <= 1'b1;
              r_prdata  <= (pwrite || w_err) ? 32'd0 : w_rdata;
              r_pslverr <= w_err;
              if (w_wr_en) begin
                case (w_off)
                  OffCtrl: begin
                    r_auto_ref_en <= pwdata[1];
                    r_init_start  <= pwdata[0];
                  end
                  OffTiming0: r_timing0 <= pwdata;
                  OffTiming1: r_timing1 <= pwdata[23:0];
                  OffScratch: r_scratch <= pwdata;
                  default:    ;
                endcase
              end
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        StResp: begin
          r_state   <= StIdle;
          r_pready  <= 1'b0;
          r_prdata  <= '0;
          r_pslverr <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign pready        = r_pready;
  assign prdata        = r_prdata;
  assign pslverr       = r_pslverr;
  assign init_start_o  = r_init_start;
  assign auto_ref_en_o = r_auto_ref_en;
  assign t_rcd_o       = r_timing0[7:0];
  assign t_rp_o        = r_timing0[15:8];
  assign t_ras_o       = r_timing0[23:16];
  assign t_rc_o        = r_timing0[31:24];
  assign t_refi_o      = r_timing1[15:0];
  assign t_rfc_o       = r_timing1[23:16];

endmodule

// File: doc/sal_apb_csr.md
# sal_apb_csr

APB completer (slave) register block for the SAL DDR controller: responds to the APB requester side of the AMBA interface set and holds the controller's control, status, DRAM timing and scratch registers. Decodes `paddr`, inserts a configurable number of wait states through an FSM, and commits writes on the completing access cycle. Sits between the SoC APB fabric and the controller core, which consumes the timing and control outputs.

## Interface
- `WAIT_CYCLES`, 1: extra access-phase cycles before `pready`; legal range 0..15.
- `VERSION`, 32'h0002_0000: value returned by the VERSION register.
- `TIMING0_RST`, 32'h1C0E_0E0E: TIMING0 reset value.
- `TIMING1_RST`, 32'h0058_0C30: TIMING1 reset value.

Ports:
- `clk`  in  1  controller clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `psel`, `penable`, `pwrite`  in  1 each  APB control.
- `paddr`  in  32  byte address; bits [11:0] decoded, upper bits ignored.
- `pwdata`  in  32  write data.
- `pready`  out  1  transfer complete.
- `prdata`  out  32  read data.
- `pslverr`  out  1  error response.
- `init_done_i`  in  1  DRAM init complete, from the core.
- `busy_i`  in  1  core has outstanding requests.
- `init_start_o`  out  1  single-cycle init kick.
- `auto_ref_en_o`  out  1  auto-refresh enable.
- `t_rcd_o`, `t_rp_o`, `t_ras_o`, `t_rc_o`  out  8 each  TIMING0 fields.
- `t_refi_o`  out  16  TIMING1[15:0]; `t_rfc_o`  out  8  TIMING1[23:16].

## Operation
- Register map (word-aligned; `paddr[1:0]` ignored):
  - 0x000 VERSION: RO.
  - 0x004 CTRL: RW. Bit0 `init_start` is write-1-pulse and reads as 0. Bit1 is `auto_ref_en`, reset 0. Bit31 is `lock`; see Configuration.
  - 0x008 STATUS: RO. Bit0 is `init_done_i`, bit1 is `busy_i`; these are sampled at the completing cycle.
  - 0x00C TIMING0: RW, holding {t_rc, t_ras, t_rp, t_rcd}.
  - 0x010 TIMING1: RW. Bits [31:24] are reserved: they read as 0 and writes to them are dropped.
  - 0x014 SCRATCH: RW, reset 0.
- FSM states IDLE, WAIT, RESP, with 4-bit counter `cnt`.
  - IDLE: `psel & !penable` at an edge -> WAIT, `cnt`=0.
  - WAIT: at each edge with `psel & penable`, `cnt==WAIT_CYCLES` -> RESP; otherwise `cnt`+1. `psel`=0 at an edge -> IDLE (abort, no commit).
  - RESP: `pready`=1 for exactly one cycle, then -> IDLE unconditionally.
- WAIT->RESP transition, all registered and applied in the same edge:
  - Write commit.
  - `prdata` load: the read value on reads, 0 on writes and on errors.
  - `pslverr` load.
- `pslverr`=1 for any of:
  - an unmapped offset (0x018..0xFFF);
  - a write to VERSION or STATUS.
- An errored write changes no state.
- A write to CTRL with bit0=1 pulses `init_start_o` high for one cycle, in the cycle `pready`=1.
- Config outputs are driven directly from the register flops.

## Timing
- Reset values:
  - `pready`=0, `prdata`=0, `pslverr`=0, `init_start_o`=0, `auto_ref_en_o`=0;
  - timing outputs from `TIMING0_RST`/`TIMING1_RST`;
  - FSM in IDLE.
- Latency: setup cycle, then `WAIT_CYCLES`+1 access cycles with `pready`=0, then one cycle with `pready`=1. Total is `WAIT_CYCLES`+3 cycles from `psel` rising.
- `prdata`/`pslverr` are valid only while `pready`=1 and are zero otherwise.
- New register values are visible on outputs in the cycle `pready`=1.
- Back-to-back transfers: the next setup phase may start the cycle after RESP, and IDLE accepts it.
- `psel & penable` seen in IDLE (protocol violation): ignored and the FSM stays in IDLE.
- `rst_n` low at any point forces reset values immediately. An in-flight write is lost.

## Configuration
- `SAL_APB_CSR_LOCK_EN` defined:
  - CTRL bit31 is a sticky `lock`, cleared only by reset.
  - While `lock`=1, writes to TIMING0/TIMING1 and to CTRL[1] return `pslverr`=1 and are dropped.
  - `init_start` and SCRATCH remain writable.
- Undefined: bit31 reads as 0, writes to it are ignored, and TIMING registers are always writable.

## Test plan
- Reset, then read every register -> VERSION=32'h0002_0000, TIMING0=32'h1C0E_0E0E, TIMING1=32'h0058_0C30, CTRL=0, SCRATCH=0, all with `pslverr`=0.
- `WAIT_CYCLES`=1: write 0xDEAD_BEEF to 0x014 -> `pready` high exactly in the 4th cycle after `psel` rises; readback returns 0xDEAD_BEEF.
- Write 0xFF1A_1B0C to 0x010 -> read returns 0x001A_1B0C, `t_refi_o`=0x1B0C, `t_rfc_o`=0x1A.
- Write to 0x008 and read 0x018 -> `pslverr`=1 and `prdata`=0; STATUS is unchanged and the FSM returns to IDLE.
- Write 0x3 to 0x004 -> `init_start_o` high for exactly 1 cycle and `auto_ref_en_o`=1; a CTRL read returns 0x2.
- With `SAL_APB_CSR_LOCK_EN` defined: write 0x8000_0000 to CTRL, then write TIMING0 -> `pslverr`=1 and TIMING0 is unchanged. Assert `rst_n` -> lock clears.
